// File: rtl/sw_sm_pkg.sv
// Shared location indices and the one-hot location encoding for the
// sw_state_machine_param program model.
package sw_sm_pkg;

    localparam int NLOC     = 9;
    localparam int LOC_L1   = 0;
    localparam int LOC_L3   = 1;
    localparam int LOC_L4   = 2;
    localparam int LOC_L5   = 3;
    localparam int LOC_L6   = 4;
    localparam int LOC_L7   = 5;
    localparam int LOC_L8   = 6;
    localparam int LOC_L9   = 7;
    localparam int LOC_L10  = 8;

    // Each location value is exactly the one-hot word driven on the loc port.
    typedef enum logic [NLOC-1:0] {
        ST_L1  = NLOC'(1) << LOC_L1,
        ST_L3  = NLOC'(1) << LOC_L3,
        ST_L4  = NLOC'(1) << LOC_L4,
        ST_L5  = NLOC'(1) << LOC_L5,
        ST_L6  = NLOC'(1) << LOC_L6,
        ST_L7  = NLOC'(1) << LOC_L7,
        ST_L8  = NLOC'(1) << LOC_L8,
        ST_L9  = NLOC'(1) << LOC_L9,
        ST_L10 = NLOC'(1) << LOC_L10
    } loc_e;

endpackage

// File: rtl/sw_sm_onehot_chk.sv
// Combinational check that the location word has exactly one bit set.
module sw_sm_onehot_chk
    import sw_sm_pkg::*;
(
    input  logic [NLOC-1:0] vec,
    output logic            one_hot
);

    // Non-zero and clearing the lowest set bit leaves nothing behind.
    assign one_hot = (vec != '0) && ((vec & (vec - NLOC'(1))) == '0);

endmodule

// File: rtl/sw_state_machine_param.sv
// Hardware model of a small guarded-counter program: one-hot location,
// state variable s, sampled input x, saturating step counter.
module sw_state_machine_param
    import sw_sm_pkg::*;
#(
    parameter int             W     = 32,
    parameter logic [W-1:0]   K_MAX = W'(2)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            inp,
    output logic [NLOC-1:0] loc,
    output logic [W-1:0]    s,
    output logic            x,
    output logic [W-1:0]    steps,
    output logic            lonehot,
    output logic            prop,
    output logic            prop_neg
);

    loc_e         loc_q, loc_d;
    logic [W-1:0] s_q, s_d;
    logic [W-1:0] steps_q;
    logic         x_q, x_d;
    logic         lonehot_q;
    logic         loc_is_onehot;
    logic         step;
    logic         s_lt;

    sw_sm_onehot_chk u_onehot_chk (
        .vec     (loc_q),
        .one_hot (loc_is_onehot)
    );

    assign step = en && lonehot_q;
    assign s_lt = (s_q < K_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            loc_q     <= ST_L1;
            s_q       <= '0;
            x_q       <= 1'b0;
            steps_q   <= '0;
            lonehot_q <= 1'b1;
        end else begin
            lonehot_q <= loc_is_onehot;
            loc_q     <= loc_d;
            s_q       <= s_d;
            x_q       <= x_d;
            if (step && (steps_q != '1)) begin
                steps_q <= steps_q + W'(1);
            end
        end
    end

    // All decisions read pre-step values; nothing moves unless a step executes.
    always_comb begin
        loc_d = loc_q;
        s_d   = s_q;
        x_d   = x_q;
        if (step) begin
            case (loc_q)
                ST_L1: loc_d = ST_L3;
                ST_L3: begin
                    if ((s_q == K_MAX) && x_q) loc_d = ST_L10;
                    else                       loc_d = ST_L4;
                end
                ST_L4: begin
                    if (s_lt) begin
                        loc_d = ST_L5;
                        x_d   = inp;
                    end else begin
                        loc_d = ST_L6;
                    end
                end
                ST_L5: loc_d = ST_L6;
                ST_L6: begin
                    if (s_lt && !s_q[0] && x_q) begin
                        loc_d = ST_L7;
                        s_d   = s_q + W'(1);
                    end else begin
                        loc_d = ST_L8;
                    end
                end
                ST_L7: loc_d = ST_L3;
                ST_L8: begin
                    if (s_lt && s_q[0] && !x_q) begin
                        loc_d = ST_L9;
                        s_d   = s_q + W'(1);
                    end else begin
                        loc_d = ST_L3;
                    end
                end
                ST_L9:  loc_d = ST_L3;
                ST_L10: loc_d = ST_L10;
                default: loc_d = loc_q;
            endcase
        end
    end

    assign loc      = loc_q;
    assign s        = s_q;
    assign x        = x_q;
    assign steps    = steps_q;
    assign lonehot  = lonehot_q;
    assign prop     = !loc[LOC_L10];
    assign prop_neg = !prop;

    // With an even terminal value the odd/even increment guards never let s
    // reach K_MAX with x set, so L10 is unreachable.
    generate
        if (K_MAX[0] == 1'b0) begin : g_safety
            a_prop: assert property (@(posedge clk) disable iff (rst) prop);
        end
    endgenerate

endmodule

// File: tb/tb_sw_state_machine_param.sv
// Bench for sw_state_machine_param: K_MAX=2 program walk with stall and
// reset, K_MAX=1 reachability of L10, and W=4 step-counter saturation.
module tb_sw_state_machine_param;
    import sw_sm_pkg::*;

    typedef struct packed {
        logic [NLOC-1:0] loc;
        logic [31:0]     s;
        logic            x;
        logic [31:0]     steps;
        logic            lonehot;
        logic            prop;
        logic            prop_neg;
    } obs_t;

    localparam int OBS_W = $bits(obs_t);

    typedef struct {
        logic            rst;
        logic            en;
        logic            inp;
        logic [NLOC-1:0] loc;
        logic [31:0]     s;
        logic            x;
        logic [31:0]     steps;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, en_a = 1'b0, inp_a = 1'b0;
    logic rst_b = 1'b1, en_b = 1'b0, inp_b = 1'b1;

    logic [NLOC-1:0] a_loc, k1_loc, w4_loc;
    logic [31:0]     a_s, a_steps, k1_s, k1_steps;
    logic [3:0]      w4_s, w4_steps;
    logic            a_x, a_lonehot, a_prop, a_prop_neg;
    logic            k1_x, k1_lonehot, k1_prop, k1_prop_neg;
    logic            w4_x, w4_lonehot, w4_prop, w4_prop_neg;

    sw_state_machine_param #(.W(32), .K_MAX(32'd2)) u_a (
        .clk(clk), .rst(rst_a), .en(en_a), .inp(inp_a),
        .loc(a_loc), .s(a_s), .x(a_x), .steps(a_steps),
        .lonehot(a_lonehot), .prop(a_prop), .prop_neg(a_prop_neg)
    );

    sw_state_machine_param #(.W(32), .K_MAX(32'd1)) u_k1 (
        .clk(clk), .rst(rst_b), .en(en_b), .inp(inp_b),
        .loc(k1_loc), .s(k1_s), .x(k1_x), .steps(k1_steps),
        .lonehot(k1_lonehot), .prop(k1_prop), .prop_neg(k1_prop_neg)
    );

    sw_state_machine_param #(.W(4), .K_MAX(4'd2)) u_w4 (
        .clk(clk), .rst(rst_b), .en(en_b), .inp(inp_b),
        .loc(w4_loc), .s(w4_s), .x(w4_x), .steps(w4_steps),
        .lonehot(w4_lonehot), .prop(w4_prop), .prop_neg(w4_prop_neg)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [OBS_W-1:0] exp_q[$];
    logic [3:0]       exp_w4_q[$];
    vec_t             tab_a[$];
    logic [NLOC-1:0]  seq028[15];
    logic [NLOC-1:0]  seq_k1[7];

    function automatic logic [NLOC-1:0] oh(input int idx);
        return NLOC'(1) << idx;
    endfunction

    function automatic vec_t mk_vec(input logic r, input logic e, input logic i,
                                    input logic [NLOC-1:0] el, input logic [31:0] es,
                                    input logic ex, input logic [31:0] est);
        vec_t v;
        v.rst = r; v.en = e; v.inp = i;
        v.loc = el; v.s = es; v.x = ex; v.steps = est;
        return v;
    endfunction

    function automatic obs_t mk_exp(input logic [NLOC-1:0] el, input logic [31:0] es,
                                    input logic ex, input logic [31:0] est);
        obs_t o;
        o.loc = el; o.s = es; o.x = ex; o.steps = est;
        o.lonehot  = 1'b1;
        o.prop     = !el[LOC_L10];
        o.prop_neg = el[LOC_L10];
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got loc=%h s=%0d x=%b steps=%0d lonehot=%b prop=%b prop_neg=%b, expected loc=%h s=%0d x=%b steps=%0d lonehot=%b prop=%b prop_neg=%b",
                     name, act.loc, act.s, act.x, act.steps, act.lonehot, act.prop, act.prop_neg,
                     exp.loc, exp.s, exp.x, exp.steps, exp.lonehot, exp.prop, exp.prop_neg);
        end
    endtask

    task automatic step_a(input string name, input vec_t v);
        obs_t act;
        @(negedge clk);
        rst_a = v.rst; en_a = v.en; inp_a = v.inp;
        exp_q.push_back(mk_exp(v.loc, v.s, v.x, v.steps));
        @(posedge clk); #1;
        act.loc = a_loc; act.s = a_s; act.x = a_x; act.steps = a_steps;
        act.lonehot = a_lonehot; act.prop = a_prop; act.prop_neg = a_prop_neg;
        check_obs(name, act, obs_t'(exp_q.pop_front()));
    endtask

    task automatic step_b(input string name, input logic r, input logic e,
                          input logic [NLOC-1:0] el, input logic [31:0] es,
                          input logic ex, input logic [31:0] est, input logic [3:0] ew4);
        obs_t act;
        logic [3:0] exp_w4;
        @(negedge clk);
        rst_b = r; en_b = e; inp_b = 1'b1;
        exp_q.push_back(mk_exp(el, es, ex, est));
        exp_w4_q.push_back(ew4);
        @(posedge clk); #1;
        act.loc = k1_loc; act.s = k1_s; act.x = k1_x; act.steps = k1_steps;
        act.lonehot = k1_lonehot; act.prop = k1_prop; act.prop_neg = k1_prop_neg;
        check_obs({name, "_k1"}, act, obs_t'(exp_q.pop_front()));
        exp_w4 = exp_w4_q.pop_front();
        n_checks++;
        if (w4_steps !== exp_w4) begin
            n_errors++;
            $display("FAIL %s_w4_steps: got %0d expected %0d", name, w4_steps, exp_w4);
        end
    endtask

    initial begin
        // K_MAX=2: walk, stall at L5, inp=0 at the second L4 visit, s sticks at 2.
        tab_a.push_back(mk_vec(1, 1, 1, oh(LOC_L1), 0, 0, 0));
        tab_a.push_back(mk_vec(0, 1, 1, oh(LOC_L3), 0, 0, 1));
        tab_a.push_back(mk_vec(0, 1, 1, oh(LOC_L4), 0, 0, 2));
        tab_a.push_back(mk_vec(0, 1, 1, oh(LOC_L5), 0, 1, 3));
        for (int i = 0; i < 5; i++)
            tab_a.push_back(mk_vec(0, 0, 0, oh(LOC_L5), 0, 1, 3));
        tab_a.push_back(mk_vec(0, 1, 1, oh(LOC_L6), 0, 1, 4));
        tab_a.push_back(mk_vec(0, 1, 1, oh(LOC_L7), 1, 1, 5));
        tab_a.push_back(mk_vec(0, 1, 1, oh(LOC_L3), 1, 1, 6));
        tab_a.push_back(mk_vec(0, 1, 1, oh(LOC_L4), 1, 1, 7));
        tab_a.push_back(mk_vec(0, 1, 0, oh(LOC_L5), 1, 0, 8));
        tab_a.push_back(mk_vec(0, 1, 1, oh(LOC_L6), 1, 0, 9));
        tab_a.push_back(mk_vec(0, 1, 1, oh(LOC_L8), 1, 0, 10));
        tab_a.push_back(mk_vec(0, 1, 1, oh(LOC_L9), 2, 0, 11));
        tab_a.push_back(mk_vec(0, 1, 1, oh(LOC_L3), 2, 0, 12));
        tab_a.push_back(mk_vec(0, 1, 1, oh(LOC_L4), 2, 0, 13));
        tab_a.push_back(mk_vec(0, 1, 1, oh(LOC_L6), 2, 0, 14));
        tab_a.push_back(mk_vec(0, 1, 1, oh(LOC_L8), 2, 0, 15));
        tab_a.push_back(mk_vec(0, 1, 1, oh(LOC_L3), 2, 0, 16));
        tab_a.push_back(mk_vec(0, 1, 1, oh(LOC_L4), 2, 0, 17));

        seq028[0]  = oh(LOC_L3); seq028[1]  = oh(LOC_L4); seq028[2]  = oh(LOC_L5);
        seq028[3]  = oh(LOC_L6); seq028[4]  = oh(LOC_L7); seq028[5]  = oh(LOC_L3);
        seq028[6]  = oh(LOC_L4); seq028[7]  = oh(LOC_L5); seq028[8]  = oh(LOC_L6);
        seq028[9]  = oh(LOC_L8); seq028[10] = oh(LOC_L3); seq028[11] = oh(LOC_L4);
        seq028[12] = oh(LOC_L5); seq028[13] = oh(LOC_L6); seq028[14] = oh(LOC_L8);

        seq_k1[0] = oh(LOC_L3); seq_k1[1] = oh(LOC_L4); seq_k1[2] = oh(LOC_L5);
        seq_k1[3] = oh(LOC_L6); seq_k1[4] = oh(LOC_L7); seq_k1[5] = oh(LOC_L3);
        seq_k1[6] = oh(LOC_L10);

        foreach (tab_a[i]) step_a($sformatf("tab_a_%0d", i), tab_a[i]);

        // inp held at 1: plain loop, then reset while parked at L8 with s=1.
        step_a("rst_028", mk_vec(1, 0, 1, oh(LOC_L1), 0, 0, 0));
        for (int i = 0; i < 15; i++)
            step_a($sformatf("seq028_%0d", i),
                   mk_vec(0, 1, 1, seq028[i], (i >= 4) ? 32'd1 : 32'd0,
                          (i >= 2) ? 1'b1 : 1'b0, 32'(i + 1)));
        step_a("rst_at_l8", mk_vec(1, 1, 1, oh(LOC_L1), 0, 0, 0));
        step_a("first_step_after_rst", mk_vec(0, 1, 1, oh(LOC_L3), 0, 0, 1));
        @(negedge clk);
        rst_a = 1'b0; en_a = 1'b0;

        // K_MAX=1 reaches L10 and sticks; W=4 counter saturates at 15.
        step_b("rst_b", 1, 1, oh(LOC_L1), 0, 0, 0, 4'd0);
        for (int n = 1; n <= 20; n++)
            step_b($sformatf("run_b_%0d", n), 0, 1,
                   (n <= 7) ? seq_k1[n-1] : oh(LOC_L10),
                   (n >= 5) ? 32'd1 : 32'd0, (n >= 3) ? 1'b1 : 1'b0,
                   32'(n), (n >= 15) ? 4'd15 : 4'(n));
        step_b("rst_at_l10", 1, 1, oh(LOC_L1), 0, 0, 0, 4'd0);

        n_checks++;
        if (exp_q.size() != 0 || exp_w4_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d entries left expected 0/0",
                     exp_q.size(), exp_w4_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
